// File: rtl/operand_compare_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : operand_compare_seq                                           |
// | Purpose  : Sequential exponent / fraction magnitude compare of two       |
// |            IEEE-754 single operands, for the front end of an adder.      |
// |            Exponents are compared in one cycle; on a tie the fractions   |
// |            are compared 8 bits per cycle, MSB chunk first.               |
// | Options  : FPU_CMP_EARLY_EXIT_EN - leave the fraction walk on the first  |
// |            unequal chunk instead of always walking all three chunks.     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module operand_compare_seq (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [31:0] OperandX,
   input  logic [31:0] OperandY,
   input  logic        Operation,
   input  logic        InValid,
   output logic        InReady,
   output logic        SignOperandX,
   output logic        SignOperandY,
   output logic        EffOperation,
   output logic        ExclusiveSign,
   output logic        DSign,
   output logic        DZF,
   output logic        CMP1,
   output logic        OutValid,
   input  logic        OutReady
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXP  = 2'd1,
      MANT = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t      state;
   state_t      state_next;

   logic [7:0]  exp_x;
   logic [7:0]  exp_y;
   logic [22:0] frac_x;
   logic [22:0] frac_y;
   logic [1:0]  chunk_idx;
   logic        decided;      // an unequal chunk has already fixed CMP1

   logic [8:0]  exp_diff;
   logic [7:0]  chunk_x;
   logic [7:0]  chunk_y;
   logic        chunk_first_ne;
   logic        mant_last;

   // Exponent difference; bit 8 is the borrow (set when Ey > Ex).
   always_comb begin
      exp_diff = {1'b0, exp_x} - {1'b0, exp_y};
   end

   // Select the fraction chunk under inspection and decide whether MANT ends.
   always_comb begin
      chunk_x = 8'd0;
      chunk_y = 8'd0;
      case (chunk_idx)
         2'd0: begin
            chunk_x = frac_x[22:15];
            chunk_y = frac_y[22:15];
         end
         2'd1: begin
            chunk_x = frac_x[14:7];
            chunk_y = frac_y[14:7];
         end
         default: begin
            chunk_x = {1'b0, frac_x[6:0]};
            chunk_y = {1'b0, frac_y[6:0]};
         end
      endcase
      chunk_first_ne = (chunk_x != chunk_y) && !decided;
`ifdef FPU_CMP_EARLY_EXIT_EN
      mant_last = (chunk_idx == 2'd2) || chunk_first_ne;
`else
      mant_last = (chunk_idx == 2'd2);
`endif
   end

   // FSM state register.
   always_ff @(posedge Clk) begin
      if (Reset) state <= IDLE;
      else       state <= state_next;
   end

   // FSM next-state and handshake outputs.
   always_comb begin
      state_next = state;
      InReady    = 1'b0;
      OutValid   = 1'b0;
      case (state)
         IDLE: begin
            InReady = 1'b1;
            if (InValid) state_next = EXP;
         end
         EXP: begin
            state_next = (exp_diff == 9'd0) ? MANT : DONE;
         end
         MANT: begin
            if (mant_last) state_next = DONE;
         end
         DONE: begin
            OutValid = 1'b1;
            // Return to IDLE only; acceptance waits for the next cycle.
            if (OutReady) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Operand capture and compare result registers.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         exp_x        <= 8'd0;
         exp_y        <= 8'd0;
         frac_x       <= 23'd0;
         frac_y       <= 23'd0;
         SignOperandX <= 1'b0;
         SignOperandY <= 1'b0;
         EffOperation <= 1'b0;
         DSign        <= 1'b0;
         DZF          <= 1'b0;
         CMP1         <= 1'b0;
         decided      <= 1'b0;
         chunk_idx    <= 2'd0;
      end else begin
         case (state)
            IDLE: begin
               if (InValid) begin
                  SignOperandX <= OperandX[31];
                  SignOperandY <= OperandY[31];
                  exp_x        <= OperandX[30:23];
                  exp_y        <= OperandY[30:23];
                  frac_x       <= OperandX[22:0];
                  frac_y       <= OperandY[22:0];
                  EffOperation <= Operation;
                  CMP1         <= 1'b0;
                  decided      <= 1'b0;
                  chunk_idx    <= 2'd0;
               end
            end
            EXP: begin
               DSign <= ~exp_diff[8];
               DZF   <= (exp_diff == 9'd0);
            end
            MANT: begin
               if (chunk_first_ne) begin
                  CMP1    <= (chunk_y > chunk_x);
                  decided <= 1'b1;
               end
               chunk_idx <= mant_last ? 2'd0 : chunk_idx + 2'd1;
            end
            default: ;
         endcase
      end
   end

   // Sign relation feeding the effective-operation decision downstream.
   always_comb begin
      ExclusiveSign = SignOperandX ^ SignOperandY;
   end

endmodule
`default_nettype wire

// File: tb/tb_operand_compare_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_operand_compare_seq                                        |
// | Purpose  : Directed self-checking bench for operand_compare_seq.         |
// |            Honours FPU_CMP_EARLY_EXIT_EN for the latency expectations.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_operand_compare_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] opx = 32'd0;
   logic [31:0] opy = 32'd0;
   logic        op = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        sign_x;
   logic        sign_y;
   logic        eff_op;
   logic        excl_sign;
   logic        dsign;
   logic        dzf;
   logic        cmp1;
   logic        out_valid;
   logic        out_ready = 1'b0;

   int checks = 0;
   int errors = 0;

`ifdef FPU_CMP_EARLY_EXIT_EN
   localparam int EARLY = 1;
`else
   localparam int EARLY = 0;
`endif

   operand_compare_seq dut (
      .Clk           (clk),
      .Reset         (rst),
      .OperandX      (opx),
      .OperandY      (opy),
      .Operation     (op),
      .InValid       (in_valid),
      .InReady       (in_ready),
      .SignOperandX  (sign_x),
      .SignOperandY  (sign_y),
      .EffOperation  (eff_op),
      .ExclusiveSign (excl_sign),
      .DSign         (dsign),
      .DZF           (dzf),
      .CMP1          (cmp1),
      .OutValid      (out_valid),
      .OutReady      (out_ready)
   );

   always #5 clk = ~clk;

   // Result field order: DSign DZF CMP1 SignX SignY EffOp ExclusiveSign
   function automatic logic [6:0] results();
      return {dsign, dzf, cmp1, sign_x, sign_y, eff_op, excl_sign};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Entry and exit: just after a rising edge, block expected in IDLE.
   task automatic run_txn(input string tag, input logic [31:0] x, input logic [31:0] y,
                          input logic o, input int exp_n, input logic [6:0] exp_res,
                          input int hold);
      int  n;
      bit  got;
      check({tag, "/in_ready_idle"}, {31'd0, in_ready}, 32'd1);
      opx = x; opy = y; op = o; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 0; got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(posedge clk); #1;
         n++;
         if (out_valid) got = 1'b1;
      end
      check({tag, "/latency"}, n, exp_n);
      check({tag, "/out_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, "/results"}, {25'd0, results()}, {25'd0, exp_res});
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         check({tag, "/hold_valid"}, {31'd0, out_valid}, 32'd1);
         check({tag, "/hold_in_ready"}, {31'd0, in_ready}, 32'd0);
         check({tag, "/hold_results"}, {25'd0, results()}, {25'd0, exp_res});
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, "/post_in_ready"}, {31'd0, in_ready}, 32'd1);
      check({tag, "/post_out_valid"}, {31'd0, out_valid}, 32'd0);
   endtask

   initial begin
      // Reset state
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("reset/in_ready", {31'd0, in_ready}, 32'd1);
      check("reset/out_valid", {31'd0, out_valid}, 32'd0);
      check("reset/results", {25'd0, results()}, 32'd0);

      // 3.0 vs 1.0, add: Ex > Ey
      run_txn("x_gt_y_exp", 32'h4040_0000, 32'h3F80_0000, 1'b0, 1, 7'b100_0000, 0);
      // 1.0 vs -3.0, sub: Ey > Ex, signs differ
      run_txn("y_gt_x_exp", 32'h3F80_0000, 32'hC040_0000, 1'b1, 1, 7'b000_0111, 0);
      // 1.5 vs 1.0: first chunk decides X larger
      run_txn("chunk0_x_gt", 32'h3FC0_0000, 32'h3F80_0000, 1'b0, (EARLY != 0) ? 2 : 4,
              7'b110_0000, 0);
      // Last-chunk difference, Y larger
      run_txn("chunk2_y_gt", 32'h3F80_0000, 32'h3F80_0001, 1'b0, 4, 7'b111_0000, 0);
      // Identical operands
      run_txn("equal", 32'h3F80_0000, 32'h3F80_0000, 1'b0, 4, 7'b110_0000, 0);
      // Chunk1 Y larger, chunk2 X larger: first unequal chunk wins
      run_txn("chunk1_wins", 32'h3F80_007F, 32'h3F80_0080, 1'b0, (EARLY != 0) ? 3 : 4,
              7'b111_0000, 0);
      // Result held for 3 cycles with OutReady low
      run_txn("hold", 32'hC040_0000, 32'h3F80_0000, 1'b1, 1, 7'b100_1011, 3);

      // Reset during MANT
      opx = 32'hBF80_0000; opy = 32'hBF80_0001; op = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("mid_reset/busy", {30'd0, in_ready, out_valid}, 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("mid_reset/in_ready", {31'd0, in_ready}, 32'd1);
      check("mid_reset/out_valid", {31'd0, out_valid}, 32'd0);
      check("mid_reset/results", {25'd0, results()}, 32'd0);
      run_txn("after_reset", 32'h4040_0000, 32'hBF80_0000, 1'b0, 1, 7'b100_0101, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Global watchdog so the bench always terminates.
   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
